// File: rtl/match_controller.sv
// Match sequencer for the two-player fighting game.
// Gates player actions, drives the shared player reset, scores rounds on
// KO or timer expiry and declares a best-of-MAX_ROUNDS winner.
// Ports:
//   clk, reset         clock (rising edge), async active-low reset
//   start              begins a match from IDLE or MATCH_OVER
//   act1_in, act2_in   raw player actions
//   p1_state, p2_state player {place[3:2], health[1:0]}
//   act1_out, act2_out gated actions, 3'b111 = NOP outside PLAY
//   player_rst_n       active-low reset to both player FSMs
//   round, score1, score2, timer, winner, done  status for display
module match_controller #(
    parameter int unsigned ROUND_TICKS  = 30,
    parameter int unsigned WIN_ROUNDS   = 2,
    parameter int unsigned MAX_ROUNDS   = 3,
    parameter int unsigned PAUSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] act1_in,
    input  logic [2:0] act2_in,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    output logic [2:0] act1_out,
    output logic [2:0] act2_out,
    output logic       player_rst_n,
    output logic [1:0] round,
    output logic [1:0] score1,
    output logic [1:0] score2,
    output logic [4:0] timer,
    output logic [1:0] winner,
    output logic       done
);

    localparam int unsigned TW = 5;
    localparam int unsigned SW = 2;
    localparam int unsigned PW = 4;
    localparam logic [2:0]  NOP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLAY,
        S_ROUND_END,
        S_MATCH_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   round_q, round_d;
    logic [SW-1:0]   score1_q, score1_d;
    logic [SW-1:0]   score2_q, score2_d;
    logic [SW-1:0]   winner_q, winner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   pause_q, pause_d;

    logic [1:0]      h1, h2;
    logic            ko1, ko2;
    logic            round_over, p1_wins, p2_wins;
    logic            unused_place;

    assign h1  = p1_state[1:0];
    assign h2  = p2_state[1:0];
    assign ko1 = (h1 == 2'd0);
    assign ko2 = (h2 == 2'd0);
    assign unused_place = ^{p1_state[3:2], p2_state[3:2]};

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= '0;
            timer_q  <= '0;
            pause_q  <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            timer_q  <= timer_d;
            pause_q  <= pause_d;
        end
    end

    // Next-state and round/score bookkeeping
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        winner_d   = winner_q;
        timer_d    = timer_q;
        pause_d    = pause_q;
        round_over = 1'b0;
        p1_wins    = 1'b0;
        p2_wins    = 1'b0;

        case (state_q)
            S_IDLE, S_MATCH_OVER: begin
                if (start) begin
                    state_d  = S_CLEAR;
                    round_d  = SW'(1);
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = '0;
                end
            end
            S_CLEAR: begin
                timer_d = TW'(ROUND_TICKS);
                state_d = S_PLAY;
            end
            S_PLAY: begin
                // KO beats expiry; the <= guard keeps the timer from wrapping
                if (ko1 || ko2) begin
                    round_over = 1'b1;
                    p1_wins    = ko2 && !ko1;
                    p2_wins    = ko1 && !ko2;
                end else if (timer_q <= TW'(1)) begin
                    round_over = 1'b1;
                    timer_d    = '0;
                    p1_wins    = (h1 > h2);
                    p2_wins    = (h2 > h1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
                if (round_over) begin
                    score1_d = score1_q + {1'b0, p1_wins};
                    score2_d = score2_q + {1'b0, p2_wins};
                    pause_d  = PW'(PAUSE_CYCLES);
                    state_d  = S_ROUND_END;
                end
            end
            S_ROUND_END: begin
                if (pause_q <= PW'(1)) begin
                    if (score1_q == SW'(WIN_ROUNDS)) begin
                        winner_d = 2'b01;
                        state_d  = S_MATCH_OVER;
                    end else if (score2_q == SW'(WIN_ROUNDS)) begin
                        winner_d = 2'b10;
                        state_d  = S_MATCH_OVER;
                    end else if (round_q == SW'(MAX_ROUNDS)) begin
                        if (score1_q > score2_q) begin
                            winner_d = 2'b01;
                        end else if (score2_q > score1_q) begin
                            winner_d = 2'b10;
                        end else begin
                            winner_d = 2'b11;
                        end
                        state_d = S_MATCH_OVER;
                    end else begin
                        round_d = round_q + SW'(1);
                        state_d = S_CLEAR;
                    end
                end else begin
                    pause_d = pause_q - PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register; actions pass through only in PLAY
    assign act1_out     = (state_q == S_PLAY) ? act1_in : NOP;
    assign act2_out     = (state_q == S_PLAY) ? act2_in : NOP;
    assign player_rst_n = !((state_q == S_IDLE) || (state_q == S_CLEAR));
    assign done         = (state_q == S_MATCH_OVER);
    assign round        = round_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign timer        = timer_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized scoreboard bench for match_controller.
module tb_match_controller;

    localparam int ROUND_TICKS  = 30;
    localparam int WIN_ROUNDS   = 2;
    localparam int MAX_ROUNDS   = 3;
    localparam int PAUSE_CYCLES = 4;
    localparam int N_CYCLES     = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] act1_in = 3'd0;
    logic [2:0] act2_in = 3'd0;
    logic [3:0] p1_state = 4'hF;
    logic [3:0] p2_state = 4'hF;
    logic [2:0] act1_out, act2_out;
    logic       player_rst_n;
    logic [1:0] round, score1, score2, winner;
    logic [4:0] timer;
    logic       done;

    match_controller #(
        .ROUND_TICKS (ROUND_TICKS),
        .WIN_ROUNDS  (WIN_ROUNDS),
        .MAX_ROUNDS  (MAX_ROUNDS),
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .act1_in     (act1_in),
        .act2_in     (act2_in),
        .p1_state    (p1_state),
        .p2_state    (p2_state),
        .act1_out    (act1_out),
        .act2_out    (act2_out),
        .player_rst_n(player_rst_n),
        .round       (round),
        .score1      (score1),
        .score2      (score2),
        .timer       (timer),
        .winner      (winner),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a1, a2, prst, rnd, s1, s2, tmr, win, dn;
    } snap_t;

    snap_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: match phase plus plain integer bookkeeping
    typedef enum {M_IDLE, M_CLEAR, M_PLAY, M_PAUSE, M_OVER} phase_t;
    phase_t ph = M_IDLE;
    int rnd = 0, s1 = 0, s2 = 0, tmr = 0, win = 0, pause_left = 0;

    function automatic void check(input string name, input int act, input int exp, input int cyc);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        ph = M_IDLE;
        rnd = 0; s1 = 0; s2 = 0; tmr = 0; win = 0; pause_left = 0;
    endfunction

    function automatic snap_t model_outputs(input logic [2:0] a1, input logic [2:0] a2);
        snap_t e;
        e.a1   = (ph == M_PLAY) ? int'(a1) : 7;
        e.a2   = (ph == M_PLAY) ? int'(a2) : 7;
        e.prst = (ph == M_IDLE || ph == M_CLEAR) ? 0 : 1;
        e.rnd  = rnd;
        e.s1   = s1;
        e.s2   = s2;
        e.tmr  = tmr;
        e.win  = win;
        e.dn   = (ph == M_OVER) ? 1 : 0;
        return e;
    endfunction

    function automatic void model_step(input logic st, input logic [3:0] q1, input logic [3:0] q2);
        int h1, h2, who;
        h1  = int'(q1[1:0]);
        h2  = int'(q2[1:0]);
        who = -1;
        case (ph)
            M_IDLE, M_OVER: if (st) begin
                ph = M_CLEAR; rnd = 1; s1 = 0; s2 = 0; win = 0;
            end
            M_CLEAR: begin
                tmr = ROUND_TICKS;
                ph  = M_PLAY;
            end
            M_PLAY: begin
                if (h1 == 0 || h2 == 0) begin
                    who = (h1 == 0 && h2 == 0) ? 0 : ((h1 == 0) ? 2 : 1);
                end else if (tmr == 1) begin
                    tmr = 0;
                    who = (h1 == h2) ? 0 : ((h1 > h2) ? 1 : 2);
                end else begin
                    tmr = tmr - 1;
                end
                if (who == 1) s1++;
                if (who == 2) s2++;
                if (who >= 0) begin
                    pause_left = PAUSE_CYCLES;
                    ph = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (pause_left > 1) pause_left--;
                else if (s1 == WIN_ROUNDS) begin win = 1; ph = M_OVER; end
                else if (s2 == WIN_ROUNDS) begin win = 2; ph = M_OVER; end
                else if (rnd == MAX_ROUNDS) begin
                    win = (s1 > s2) ? 1 : ((s2 > s1) ? 2 : 3);
                    ph  = M_OVER;
                end else begin
                    rnd++;
                    ph = M_CLEAR;
                end
            end
            default: ph = M_IDLE;
        endcase
    endfunction

    // Monitor: pop one expected snapshot per cycle and compare
    initial begin
        forever begin
            snap_t e;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                check("act1_out",     int'(act1_out),     e.a1,   int'($time / 10));
                check("act2_out",     int'(act2_out),     e.a2,   int'($time / 10));
                check("player_rst_n", int'(player_rst_n), e.prst, int'($time / 10));
                check("round",        int'(round),        e.rnd,  int'($time / 10));
                check("score1",       int'(score1),       e.s1,   int'($time / 10));
                check("score2",       int'(score2),       e.s2,   int'($time / 10));
                check("timer",        int'(timer),        e.tmr,  int'($time / 10));
                check("winner",       int'(winner),       e.win,  int'($time / 10));
                check("done",         int'(done),         e.dn,   int'($time / 10));
            end
        end
    end

    // Driver: random stimulus, per-round player behaviour modes, occasional resets
    initial begin
        int  mode, h1c, h2c, ko_at, play_cnt, hh1, hh2;
        bit  did_target, did_forced;
        logic rst_now;
        mode = 0; h1c = 3; h2c = 3; ko_at = 1; play_cnt = 0;
        did_target = 1'b0; did_forced = 1'b0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            rst_now = 1'b0;
            if (cyc < 3) rst_now = 1'b1;
            else if (ph == M_PLAY && tmr == 12 && s2 == 1 && !did_target) begin
                rst_now = 1'b1; did_target = 1'b1;
            end else if (ph == M_PLAY && cyc > 3000 && !did_forced) begin
                rst_now = 1'b1; did_forced = 1'b1;
            end else if ($urandom_range(0, 999) == 0) rst_now = 1'b1;

            if (ph == M_CLEAR) begin
                mode     = int'($urandom_range(0, 2));
                h1c      = int'($urandom_range(1, 3));
                h2c      = int'($urandom_range(1, 3));
                ko_at    = int'($urandom_range(1, ROUND_TICKS + 3));
                play_cnt = 0;
            end
            if (ph == M_PLAY) begin
                play_cnt++;
                case (mode)
                    0: begin hh1 = h1c; hh2 = h2c; end
                    1: begin
                        hh1 = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 3));
                        hh2 = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 3));
                    end
                    default: begin
                        hh1 = (play_cnt == ko_at) ? 0 : h1c;
                        hh2 = (play_cnt == ko_at) ? 0 : h2c;
                    end
                endcase
            end else begin
                hh1 = int'($urandom_range(0, 3));
                hh2 = int'($urandom_range(0, 3));
            end

            if (ph == M_IDLE || ph == M_OVER) start = ($urandom_range(0, 3) == 0);
            else start = 1'($urandom_range(0, 1));
            act1_in  = 3'($urandom_range(0, 7));
            act2_in  = 3'($urandom_range(0, 7));
            p1_state = {2'($urandom_range(0, 3)), 2'(hh1)};
            p2_state = {2'($urandom_range(0, 3)), 2'(hh2)};
            reset    = !rst_now;

            if (rst_now) model_reset();
            exp_q.push_back(model_outputs(act1_in, act2_in));
            if (!rst_now) model_step(start, p1_state, p2_state);
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
